// File: rtl/cvt_i_fp_mod.sv
// cvt_i_fp_mod: pipelined integer -> 82-bit extended-precision converter.
//
// Takes a 64-bit or 32-bit, signed or unsigned integer and normalises it
// exactly into a 64-bit mantissa with an explicit integer bit and a 16-bit
// biased exponent. The result is packed into the internal 82-bit operand word.
//
// Ports:
//   clk      : clock, posedge
//   rst      : asynchronous reset, active low
//   en       : conversion request this cycle
//   clkEn    : pipeline advance; 0 holds every stage
//   flush    : kills all in-flight operations (wins over clkEn and en)
//   A        : operand, A[63:0] used, A[64] ignored
//   is32b    : operand is A[31:0]
//   isSigned : operand is two's complement
//   res      : packed result, holds while valid=0
//   valid    : res is a completed conversion
module cvt_i_fp_mod #(
  parameter logic [15:0] BIAS = 16'h7fff,
  parameter int          LAT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clkEn,
  input  logic        flush,
  input  logic [64:0] A,
  input  logic        is32b,
  input  logic        isSigned,
  output logic [81:0] res,
  output logic        valid
);

  // valid shift register, one bit per stage; the top bit is the output valid
  logic [LAT:1] r_vld_pipe;

  logic [63:0] w_val, w_mag;
  logic        w_neg;
  logic        w_unused;

  logic [63:0] r1_mag;
  logic        r1_neg;

  logic [5:0]  w_lz;
  logic        w_z;

  logic [63:0] r2_mag;
  logic        r2_neg;
  logic [5:0]  r2_lz;
  logic        r2_z;

  logic [63:0] w_m;
  logic [15:0] w_e;
  logic        w_sign;

  assign w_unused = A[64];

  // Stage 1: operand select and magnitude. -2^63 negates to itself, which
  // is the correct unsigned magnitude.
  assign w_val = is32b ? {{32{isSigned & A[31]}}, A[31:0]} : A[63:0];
  assign w_neg = isSigned & w_val[63];
  assign w_mag = w_neg ? (~w_val + 64'd1) : w_val;

  // Stage 2: leading-zero count; the highest set bit wins because it is
  // visited last. A zero magnitude is flagged separately.
  always_comb begin
    w_lz = 6'd63;
    for (int i = 0; i < 64; i++)
      if (r1_mag[i]) w_lz = 6'(63 - i);
  end
  assign w_z = (r1_mag == 64'd0);

  // Stage 3: normalise; zero forces an all-zero word (no negative zero)
  assign w_m    = r2_z ? 64'd0 : (r2_mag << r2_lz);
  assign w_e    = r2_z ? 16'd0 : 16'(BIAS + 16'd63 - {10'd0, r2_lz});
  assign w_sign = r2_neg & ~r2_z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_vld_pipe <= '0;
    else if (flush) r_vld_pipe <= '0;
    else if (clkEn) r_vld_pipe <= {r_vld_pipe[LAT-1:1], en};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_mag <= '0;
      r1_neg <= 1'b0;
      r2_mag <= '0;
      r2_neg <= 1'b0;
      r2_lz  <= '0;
      r2_z   <= 1'b0;
    end else if (clkEn) begin
      r1_mag <= w_mag;
      r1_neg <= w_neg;
      r2_mag <= r1_mag;
      r2_neg <= r1_neg;
      r2_lz  <= w_lz;
      r2_z   <= w_z;
    end
  end

  // res only changes when a real result lands, so it holds while valid=0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      res <= '0;
    else if (clkEn && !flush && r_vld_pipe[LAT-1])
      res <= {w_e[14], w_sign, w_e[15], w_e[13:0], w_m[63:32], 1'b0, w_m[31:0]};
  end

  assign valid = r_vld_pipe[LAT];

endmodule

// File: tb/tb_cvt_i_fp_mod.sv
// Scoreboard bench for cvt_i_fp_mod: the driver pushes hand-computed results,
// the monitor pops on every new valid output and checks holds during stalls.
module tb_cvt_i_fp_mod;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clkEn = 1'b1;
  logic        flush = 1'b0;
  logic        is32b = 1'b0;
  logic        isSigned = 1'b0;
  logic [64:0] A = '0;
  logic [81:0] res;
  logic        valid;

  logic [81:0] exp_q[$];
  logic [81:0] last_res = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  cvt_i_fp_mod dut (
    .clk(clk), .rst(rst), .en(en), .clkEn(clkEn), .flush(flush),
    .A(A), .is32b(is32b), .isSigned(isSigned), .res(res), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [81:0] pk(input logic s, input logic [15:0] e, input logic [63:0] m);
    return {e[14], s, e[15], e[13:0], m[63:32], 1'b0, m[31:0]};
  endfunction

  // Monitor
  always @(posedge clk) begin
    logic        adv, fl, rs;
    logic [81:0] ex;
    adv = clkEn;
    fl  = flush;
    rs  = rst;
    #1;
    if (rs && fl) begin
      n_chk++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_valid: valid=%b required 0", valid);
      end
    end else if (rs && adv && valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: res=%h with no conversion outstanding", res);
      end else begin
        ex = exp_q.pop_front();
        if (res !== ex) begin
          n_fail++;
          $display("FAIL result: res=%h required %h", res, ex);
        end
      end
      last_res = res;
    end else if (rs && !adv && valid) begin
      n_chk++;
      if (res !== last_res) begin
        n_fail++;
        $display("FAIL stall_hold: res=%h required %h", res, last_res);
      end
    end
  end

  task automatic issue(input logic [64:0] a, input logic i32, input logic sg, input logic [81:0] ex);
    en = 1'b1; A = a; is32b = i32; isSigned = sg;
    exp_q.push_back(ex);
    @(negedge clk);
    en = 1'b0;
  endtask

  // issue without an expectation (operation is meant to be killed)
  task automatic issue_np(input logic [64:0] a);
    en = 1'b1; A = a; is32b = 1'b0; isSigned = 1'b0;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [81:0] act, input logic [81:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset_valid", {81'd0, valid}, 82'd0);
    check("reset_res", res, 82'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed vectors, back to back
    issue(65'd1, 1'b0, 1'b1, pk(1'b0, 16'h7fff, 64'h8000_0000_0000_0000));
    issue({1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, 1'b1, pk(1'b1, 16'h7fff, 64'h8000_0000_0000_0000));
    issue({1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, 1'b0, pk(1'b0, 16'h803e, 64'hFFFF_FFFF_FFFF_FFFF));
    issue({1'b0, 64'h8000_0000_0000_0000}, 1'b0, 1'b1, pk(1'b1, 16'h803e, 64'h8000_0000_0000_0000));
    issue({1'b0, 64'h8000_0000_0000_0000}, 1'b0, 1'b0, pk(1'b0, 16'h803e, 64'h8000_0000_0000_0000));
    issue(65'd0, 1'b0, 1'b1, 82'd0);
    issue({1'b0, 64'h0000_0000_FFFF_FFFF}, 1'b1, 1'b0, pk(1'b0, 16'h801e, 64'hFFFF_FFFF_0000_0000));
    issue({1'b0, 64'h0000_0000_FFFF_FFFF}, 1'b1, 1'b1, pk(1'b1, 16'h7fff, 64'h8000_0000_0000_0000));
    issue({1'b1, 64'h0000_0000_0000_0001}, 1'b0, 1'b0, pk(1'b0, 16'h7fff, 64'h8000_0000_0000_0000));
    issue({1'b0, 64'hDEAD_BEEF_0000_0010}, 1'b1, 1'b0, pk(1'b0, 16'h8003, 64'h8000_0000_0000_0000));
    issue({1'b0, 64'hFFFF_FFFF_FFFF_FFFA}, 1'b0, 1'b1, pk(1'b1, 16'h8001, 64'hC000_0000_0000_0000));
    idle(5);

    // back-to-back with stalls
    issue(65'd5, 1'b0, 1'b0, pk(1'b0, 16'h8001, 64'hA000_0000_0000_0000));
    issue(65'd6, 1'b0, 1'b0, pk(1'b0, 16'h8001, 64'hC000_0000_0000_0000));
    clkEn = 1'b0;
    idle(2);
    clkEn = 1'b1;
    issue(65'd7, 1'b0, 1'b0, pk(1'b0, 16'h8001, 64'hE000_0000_0000_0000));
    idle(1);
    clkEn = 1'b0;
    idle(2);
    clkEn = 1'b1;
    idle(5);

    // flush one cycle after en
    issue_np(65'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(4);
    // flush beats same-cycle en
    en = 1'b1; A = 65'd3; flush = 1'b1;
    @(negedge clk);
    en = 1'b0; flush = 1'b0;
    idle(4);

    // reset with operations in flight; res currently holds a nonzero result
    issue_np(65'd9);
    issue_np(65'd10);
    en = 1'b1; A = 65'd11;
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {81'd0, valid}, 82'd0);
    check("async_rst_res", res, 82'd0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(6);
    check("post_rst_res", res, 82'd0);
    issue(65'd5, 1'b0, 1'b1, pk(1'b0, 16'h8001, 64'hA000_0000_0000_0000));

    // bounded drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    idle(2);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cvt_i_fp_mod.md
Name: cvt_I_FP_mod

Overview:
Pipelined integer-to-floating-point converter producing the 82-bit internal extended-precision operand word consumed by the FP datapath and by the FP-to-integer converter. It accepts a 64-bit or 32-bit, signed or unsigned integer and normalises it exactly into a 64-bit explicit-integer-bit mantissa with a 16-bit biased exponent. Three-stage pipeline, stallable by clkEn, with a valid bit carried alongside the data.

Parameters:
BIAS, 16'h7fff, exponent bias of the extended format.
LAT, 3, pipeline depth in cycles; fixed, not meant to be overridden.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous active-low reset.
en  input  1  operation request this cycle.
clkEn  input  1  pipeline advance enable; 0 = hold all stages.
flush  input  1  synchronous kill of all in-flight operations.
A  input  65  integer operand; A[63:0] used, A[64] ignored.
is32b  input  1  operand is A[31:0] only.
isSigned  input  1  operand is two's complement.
res  output  82  packed extended-format result.
valid  output  1  res is a completed conversion.

Behaviour:
- Reset (rst=0, asynchronous): every pipeline register, including all valid bits, cleared; res=82'b0, valid=0 until the first conversion completes.
- Advance: all stages load only when clkEn=1; with clkEn=0, every stage and the outputs hold their values.
- Latency: en sampled with clkEn=1 at edge N gives valid=1 after edge N+2 of clkEn=1, i.e. 3 advancing edges including N. Throughput is one operation per advancing cycle.
- flush=1 at an edge clears all valid bits, regardless of clkEn. Data registers are don't-care. flush takes priority over a same-cycle en.
- Stage 1, operand select:
  - is32b=1: value = sign- or zero-extension of A[31:0], chosen by isSigned.
  - Else value = A[63:0].
  - neg = isSigned & value[63].
  - mag = neg ? -value : value, as a 64-bit unsigned result; -2^63 yields 0x8000_0000_0000_0000.
  - Register mag, neg, valid.
- Stage 2: 64-bit leading-zero count lz (0..63) of mag, plus zero flag z = (mag==0). Register mag, neg, lz, z, valid.
- Stage 3, normalise and pack:
  - m = mag << lz; bit 63 of m is the explicit integer bit.
  - e = BIAS + 63 - lz, 16-bit.
  - If z: e=0, m=0, sign=0; negative zero is never produced.
  - Conversion is always exact; there is no rounding and no exception.
- Pack:
  - res[80]=sign
  - res[79]=e[15], res[81]=e[14], res[78:65]=e[13:0]
  - res[64:33]=m[63:32], res[32]=0, res[31:0]=m[31:0]
- Outputs are registered. res keeps its last value while valid=0.
- Reset asserted mid-operation discards all in-flight conversions immediately; no partial result appears after reset is released.

Test Plan:
- A=1, is32b=0, isSigned=1, clkEn=1 -> after 3 edges valid=1; e=0x7fff, so res[81]=1, res[79]=0, res[78:65]=0x3fff; m=0x8000_0000_0000_0000; res[80]=0.
- A=0xFFFF_FFFF_FFFF_FFFF, isSigned=1 -> sign=1, e=0x7fff, m=0x8000_0000_0000_0000. Same A with isSigned=0 -> sign=0, e=0x803e, m=0xFFFF_FFFF_FFFF_FFFF.
- A=0x8000_0000_0000_0000, isSigned=1 -> sign=1, e=0x803e, m=0x8000_0000_0000_0000. A=0 -> res=82'b0, valid=1.
- is32b=1, A[31:0]=0xFFFF_FFFF, isSigned=0 -> e=0x801e, m=0xFFFF_FFFF_0000_0000. Same operand with isSigned=1 -> sign=1, e=0x7fff, m=0x8000_0000_0000_0000.
- Back-to-back operands 5, 6, 7, with clkEn dropped for 2 cycles after the second -> results appear in order and each stays stable while stalled; 5 -> e=0x8001, m=0xA000_0000_0000_0000.
- flush asserted one cycle after en -> no valid pulse for that operation. rst pulsed low with 3 operations in flight -> valid=0 and res=0 immediately; no stale result after release.
